masked_sram_1r1w_ext: RTL and testbench

Parametrised one-read/one-write SRAM behavioural model with per-lane write masks, the next generation of the single-port masked array macros. It adds independent read and write ports, a 1- or 2-cycle read pipeline, same-address write-to-read forwarding, and a hardware zero-initialisation sweep after reset. It sits under generated cache and predictor arrays as the `_ext` macro the memory compiler substitutes.

---
 rtl/masked_sram_pkg.sv | 33 +++
 rtl/masked_sram_init_fsm.sv | 62 ++++++
 rtl/masked_sram_1r1w_ext.sv | 157 +++++++++++++++
 tb/tb_masked_sram_1r1w_ext.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_sram_pkg.sv
// Shared types and helpers for the masked 1R1W SRAM model.
// Holds the init/ready state encoding and the per-lane merge used by both
// the array write path and same-address read forwarding.
package masked_sram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_t;

    // Widest entry the merge helper handles; callers zero-extend into it and
    // keep only their own DATA_W low bits (DATA_W must stay below this).
    localparam int MERGE_MAX_W = 256;
    localparam int MERGE_IDX_W = $clog2(MERGE_MAX_W);

    // Bit b takes new_dat when its lane (b / gran) is enabled, else old_dat.
    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0] old_dat,
        input logic [MERGE_MAX_W-1:0] new_dat,
        input logic [MERGE_MAX_W-1:0] mask,
        input int                     gran
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_dat;
        for (int b = 0; b < MERGE_MAX_W; b++) begin
            if (mask[MERGE_IDX_W'(b / gran)]) begin
                res[MERGE_IDX_W'(b)] = new_dat[MERGE_IDX_W'(b)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/masked_sram_init_fsm.sv
// Init sweep controller: after reset walks every entry once, then reports ready.
// Ports: clock/reset in; ready, init_we, init_addr out (init write owns the array port while sweeping).
// ready is combinationally gated by reset so it drops/rises together with reset.
module masked_sram_init_fsm
    import masked_sram_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int INIT_ZERO = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    localparam sram_state_t       RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sram_state_t       state;
    sram_state_t       state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        init_we   = 1'b0;
        case (state)
            ST_INIT: begin
                // No sweep write on an edge where reset is still held.
                init_we = ~reset;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end
            end
            ST_READY: begin
                ready = ~reset;
            end
            default: begin
                state_nxt = RST_STATE;
            end
        endcase
    end

    assign init_addr = cnt;

endmodule

// File: rtl/masked_sram_1r1w_ext.sv
// 1R1W SRAM model with per-lane write masks, optional write->read forwarding and init sweep.
// Ports: clock/reset; ready; R0 read request (en/addr) -> R0_valid/R0_data after RD_LAT edges; W0 masked write.
// Requests are ignored while ready=0; reads run at full rate, no stall once ready.
module masked_sram_1r1w_ext
    import masked_sram_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int DATA_W    = 20,
    parameter int GRAN      = 2,
    parameter int MASK_W    = DATA_W / GRAN,
    parameter int RD_LAT    = 1,
    parameter int FWD       = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic              R0_en,
    input  logic [ADDR_W-1:0] R0_addr,
    output logic              R0_valid,
    output logic [DATA_W-1:0] R0_data,
    input  logic              W0_en,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic [MASK_W-1:0] W0_mask,
    input  logic [DATA_W-1:0] W0_data
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] ram [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    masked_sram_init_fsm #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_init_fsm (
        .clock     (clock),
        .reset     (reset),
        .ready     (ready),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    logic rd_in_range;
    logic wr_in_range;
    logic rd_fire;
    logic wr_fire;
    logic collide;

    assign rd_in_range = {1'b0, R0_addr} < DEPTH_LIM;
    assign wr_in_range = {1'b0, W0_addr} < DEPTH_LIM;
    assign rd_fire     = R0_en & ready;
    // ready already folds in reset, so a write coincident with reset is dropped.
    assign wr_fire     = W0_en & ready & wr_in_range;
    assign collide     = (FWD != 0) & rd_fire & wr_fire & (R0_addr == W0_addr);

    // Array write port: the init sweep owns it until ready.
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_dat;
    logic [MASK_W-1:0] arr_mask;

    always_comb begin
        arr_we   = wr_fire;
        arr_addr = W0_addr;
        arr_dat  = W0_data;
        arr_mask = W0_mask;
        if (init_we) begin
            arr_we   = 1'b1;
            arr_addr = init_addr;
            arr_dat  = '0;
            arr_mask = '1;
        end
    end

    logic [MERGE_MAX_W-1:0] wr_merge_wide;
    logic [MERGE_MAX_W-1:0] fwd_merge_wide;
    logic [DATA_W-1:0]      rd_old;
    logic [DATA_W-1:0]      rd_dat;
    logic                   unused_merge_hi;

    assign wr_merge_wide  = lane_merge(MERGE_MAX_W'(ram[arr_addr]), MERGE_MAX_W'(arr_dat),
                                       MERGE_MAX_W'(arr_mask), GRAN);
    // Out-of-range reads return zero rather than aliasing another entry.
    assign rd_old         = rd_in_range ? ram[R0_addr] : '0;
    assign fwd_merge_wide = lane_merge(MERGE_MAX_W'(rd_old), MERGE_MAX_W'(W0_data),
                                       MERGE_MAX_W'(W0_mask), GRAN);
    assign rd_dat         = collide ? fwd_merge_wide[DATA_W-1:0] : rd_old;
    assign unused_merge_hi = ^{wr_merge_wide[MERGE_MAX_W-1:DATA_W],
                               fwd_merge_wide[MERGE_MAX_W-1:DATA_W]};

    always_ff @(posedge clock) begin
        if (arr_we) begin
            ram[arr_addr] <= wr_merge_wide[DATA_W-1:0];
        end
    end

    // Capture stage: the array is sampled on the request edge, so later writes
    // to the same address cannot disturb a read already in flight.
    logic              cap_vld;
    logic [DATA_W-1:0] cap_dat;
    logic              src_vld;
    logic [DATA_W-1:0] src_dat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_vld <= 1'b0;
            cap_dat <= '0;
        end else begin
            cap_vld <= rd_fire;
            if (rd_fire) begin
                cap_dat <= rd_dat;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              mid_vld;
            logic [DATA_W-1:0] mid_dat;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    mid_vld <= 1'b0;
                    mid_dat <= '0;
                end else begin
                    mid_vld <= cap_vld;
                    if (cap_vld) begin
                        mid_dat <= cap_dat;
                    end
                end
            end
            assign src_vld = mid_vld;
            assign src_dat = mid_dat;
        end else begin : g_lat1
            assign src_vld = cap_vld;
            assign src_dat = cap_dat;
        end
    endgenerate

    // Output register: R0_data only moves with a valid pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            R0_valid <= 1'b0;
            R0_data  <= '0;
        end else begin
            R0_valid <= src_vld;
            if (src_vld) begin
                R0_data <= src_dat;
            end
        end
    end

endmodule

// File: tb/tb_masked_sram_1r1w_ext.sv
// Directed bench for masked_sram_1r1w_ext: two instances share all inputs.
// u_a: DEPTH=16, RD_LAT=1, FWD=1.  u_b: DEPTH=12, RD_LAT=2, FWD=0.
// Outputs are sampled 1 time unit after each rising edge.
module tb_masked_sram_1r1w_ext;

    logic        clock;
    logic        reset;
    logic        r_en;
    logic [3:0]  r_addr;
    logic        w_en;
    logic [3:0]  w_addr;
    logic [9:0]  w_mask;
    logic [19:0] w_data;

    logic        a_ready;
    logic        a_vld;
    logic [19:0] a_dat;
    logic        b_ready;
    logic        b_vld;
    logic [19:0] b_dat;

    int n_checks = 0;
    int n_errors = 0;

    masked_sram_1r1w_ext #(
        .DEPTH(16), .DATA_W(20), .GRAN(2), .RD_LAT(1), .FWD(1), .INIT_ZERO(1)
    ) u_a (
        .clock    (clock),
        .reset    (reset),
        .ready    (a_ready),
        .R0_en    (r_en),
        .R0_addr  (r_addr),
        .R0_valid (a_vld),
        .R0_data  (a_dat),
        .W0_en    (w_en),
        .W0_addr  (w_addr),
        .W0_mask  (w_mask),
        .W0_data  (w_data)
    );

    masked_sram_1r1w_ext #(
        .DEPTH(12), .DATA_W(20), .GRAN(2), .RD_LAT(2), .FWD(0), .INIT_ZERO(1)
    ) u_b (
        .clock    (clock),
        .reset    (reset),
        .ready    (b_ready),
        .R0_en    (r_en),
        .R0_addr  (r_addr),
        .R0_valid (b_vld),
        .R0_data  (b_dat),
        .W0_en    (w_en),
        .W0_addr  (w_addr),
        .W0_mask  (w_mask),
        .W0_data  (w_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [19:0] dat, input logic [9:0] mask);
        w_en   = 1'b1;
        w_addr = addr;
        w_data = dat;
        w_mask = mask;
        tick();
        w_en   = 1'b0;
    endtask

    // Single read: A answers one edge after the request edge, B two.
    task automatic do_read(input string tag, input logic [3:0] addr,
                           input logic [19:0] exp_a, input logic [19:0] exp_b);
        r_en   = 1'b1;
        r_addr = addr;
        tick();
        r_en   = 1'b0;
        tick();
        chk({tag, "_a_vld"}, 32'(a_vld), 32'd1);
        chk({tag, "_a_dat"}, 32'(a_dat), 32'(exp_a));
        tick();
        chk({tag, "_b_vld"}, 32'(b_vld), 32'd1);
        chk({tag, "_b_dat"}, 32'(b_dat), 32'(exp_b));
    endtask

    // Counts edges after reset release until each ready rises (bounded).
    task automatic count_ready(output int ea, output int eb, output logic saw_vld);
        ea      = 0;
        eb      = 0;
        saw_vld = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ea == 0 && a_ready) ea = i;
            if (eb == 0 && b_ready) eb = i;
            if (a_vld || b_vld) saw_vld = 1'b1;
        end
    endtask

    initial begin
        int   ea;
        int   eb;
        logic saw;

        reset  = 1'b1;
        r_en   = 1'b0;
        r_addr = '0;
        w_en   = 1'b0;
        w_addr = '0;
        w_mask = '0;
        w_data = '0;
        tick();
        tick();

        // Reset values
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_a_vld",   32'(a_vld),   32'd0);
        chk("rst_a_dat",   32'(a_dat),   32'd0);
        chk("rst_b_vld",   32'(b_vld),   32'd0);
        chk("rst_b_dat",   32'(b_dat),   32'd0);

        reset = 1'b0;
        count_ready(ea, eb, saw);
        chk("init_a_edges", 32'(ea), 32'd16);
        chk("init_b_edges", 32'(eb), 32'd12);

        // Fill with garbage, then reset: the sweep must clear it all.
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 20'hA5A5A ^ 20'(i * 4099), 10'h3FF);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_ready(ea, eb, saw);
        chk("reinit_a_edges", 32'(ea), 32'd16);
        chk("reinit_b_edges", 32'(eb), 32'd12);

        // Back-to-back reads of every address: all zero, full throughput.
        for (int c = 0; c < 18; c++) begin
            r_en   = (c < 16);
            r_addr = 4'(c);
            tick();
            if (c >= 1 && c <= 16) begin
                chk($sformatf("sweep_a_vld%0d", c - 1), 32'(a_vld), 32'd1);
                chk($sformatf("sweep_a_dat%0d", c - 1), 32'(a_dat), 32'd0);
            end
            if (c >= 2) begin
                chk($sformatf("sweep_b_vld%0d", c - 2), 32'(b_vld), 32'd1);
                chk($sformatf("sweep_b_dat%0d", c - 2), 32'(b_dat), 32'd0);
            end
        end
        r_en = 1'b0;
        tick();
        chk("b2b_a_vld_end", 32'(a_vld), 32'd0);
        chk("b2b_b_vld_end", 32'(b_vld), 32'd0);

        // Masked writes: full write, low-two-lane write, then a no-op mask.
        do_write(4'd5, 20'hABCDE, 10'h3FF);
        do_write(4'd5, 20'hFFFFF, 10'h003);
        do_write(4'd5, 20'h00000, 10'h000);
        do_read("mask5", 4'd5, 20'hABCDF, 20'hABCDF);

        // Same-cycle collision on addr 3 (holds zero).
        r_en   = 1'b1;
        r_addr = 4'd3;
        w_en   = 1'b1;
        w_addr = 4'd3;
        w_data = 20'h12345;
        w_mask = 10'h3E0;
        tick();
        r_en = 1'b0;
        w_en = 1'b0;
        chk("col_a_vld_early", 32'(a_vld), 32'd0);
        tick();
        chk("col_a_vld", 32'(a_vld), 32'd1);
        chk("col_a_dat", 32'(a_dat), 32'h12000);
        chk("col_b_vld_early", 32'(b_vld), 32'd0);
        tick();
        chk("col_b_vld", 32'(b_vld), 32'd1);
        chk("col_b_dat", 32'(b_dat), 32'h00000);
        chk("col_a_pulse", 32'(a_vld), 32'd0);
        chk("col_a_hold",  32'(a_dat), 32'h12000);
        do_read("after_col", 4'd3, 20'h12000, 20'h12000);

        // Write in the cycle after a read must not reach the in-flight data.
        r_en   = 1'b1;
        r_addr = 4'd7;
        tick();
        r_en   = 1'b0;
        w_en   = 1'b1;
        w_addr = 4'd7;
        w_data = 20'h55555;
        w_mask = 10'h3FF;
        tick();
        w_en = 1'b0;
        chk("war_a_dat", 32'(a_dat), 32'd0);
        tick();
        chk("war_b_vld", 32'(b_vld), 32'd1);
        chk("war_b_dat", 32'(b_dat), 32'd0);
        do_read("war_after", 4'd7, 20'h55555, 20'h55555);

        // Addr 13: in range for A, out of range for B.
        do_write(4'd13, 20'h77777, 10'h3FF);
        do_read("oor13", 4'd13, 20'h77777, 20'h00000);
        do_read("oor_alias1", 4'd1, 20'h00000, 20'h00000);
        do_read("oor_keep5",  4'd5, 20'hABCDF, 20'hABCDF);

        // Reset with reads in flight.
        r_en   = 1'b1;
        r_addr = 4'd5;
        tick();
        r_addr = 4'd3;
        tick();
        chk("mid_a_vld_pre", 32'(a_vld), 32'd1);
        r_en  = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_a_vld", 32'(a_vld), 32'd0);
        chk("mid_b_vld", 32'(b_vld), 32'd0);
        chk("mid_a_dat", 32'(a_dat), 32'd0);
        chk("mid_b_dat", 32'(b_dat), 32'd0);
        chk("mid_a_ready", 32'(a_ready), 32'd0);
        tick();
        reset = 1'b0;
        count_ready(ea, eb, saw);
        chk("mid_a_edges", 32'(ea), 32'd16);
        chk("mid_b_edges", 32'(eb), 32'd12);
        chk("mid_no_late_vld", 32'(saw), 32'd0);
        do_read("mid_swept5", 4'd5, 20'h00000, 20'h00000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
